// File: rtl/wb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// wb_hazard_ctrl
//   Pipeline sequencer for the IF/ID, ID/EX and EX/WB registers.
//   - Redirects the PC from the EX/WB control bits and squashes wrong-path work.
//   - Stalls the front end on RAW hazards against the EX and WB destinations.
//   - Keeps saturating stall/flush counters for performance debug.
//
// Ports
//   clk, reset             pipeline clock, synchronous active-high reset
//   id_rs/id_rt            source specifiers of the ID instruction
//   id_uses_rs/id_uses_rt  which sources the ID instruction actually reads
//   idex_rd/idex_reg_write destination of the instruction in EX
//   exwb_rd/exwb_reg_write destination held in the EX/WB register
//   exwb_n/exwb_z          flags latched in EX/WB
//   exwb_branch_neg/_z, exwb_jump, exwb_jump_mem  control bits latched in EX/WB
//   pc_sel                 00 PC+1, 01 EX/WB addr_out, 10 EX/WB data_mem_out
//   pc_write, ifid_write   load enables
//   ifid_flush, idex_flush, exwb_flush  squash controls
//   stall_cnt, flush_cnt   saturating performance counters
// -----------------------------------------------------------------------------
module wb_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int REG_W        = 6,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] idex_rd,
    input  logic             idex_reg_write,
    input  logic [REG_W-1:0] exwb_rd,
    input  logic             exwb_reg_write,
    input  logic             exwb_n,
    input  logic             exwb_z,
    input  logic             exwb_branch_neg,
    input  logic             exwb_branch_z,
    input  logic             exwb_jump,
    input  logic             exwb_jump_mem,
    output logic [1:0]       pc_sel,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exwb_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_reg;
    logic [3:0]       flush_left_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic             take;
    logic             hazard;
    logic             in_flush;
    logic             redirect;

    // Per-source hazard detection; register 0 is compared like any other.
    logic [REG_W-1:0] src      [2];
    logic [1:0]       src_used;
    logic [1:0]       src_hit;

    assign src[0]      = id_rs;
    assign src[1]      = id_rt;
    assign src_used[0] = id_uses_rs;
    assign src_used[1] = id_uses_rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] &
                                 ((idex_reg_write & (src[gi] == idex_rd)) |
                                  (exwb_reg_write & (src[gi] == exwb_rd)));
        end
    endgenerate

    assign hazard   = |src_hit;
    assign take     = exwb_jump | exwb_jump_mem |
                      (exwb_branch_neg & exwb_n) | (exwb_branch_z & exwb_z);
    assign in_flush = (state_reg == ST_FLUSH);
    // While flushing, EX/WB carries wrong-path bits, so its take is ignored.
    assign redirect = take & ~in_flush;

    // Control outputs are combinational so a redirect acts in the same cycle.
    always_comb begin
        pc_sel     = 2'b00;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exwb_flush = 1'b0;
        if (reset) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exwb_flush = 1'b1;
        end else begin
            if (redirect) begin
                pc_sel     = exwb_jump_mem ? 2'b10 : 2'b01;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (hazard) begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_flush = 1'b1;
            end
            if (in_flush) begin
                exwb_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_RUN;
            flush_left_reg <= 4'd0;
            stall_cnt_reg  <= '0;
            flush_cnt_reg  <= '0;
        end else begin
            if (redirect && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
            if (hazard && !redirect && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end

            if (redirect) begin
                state_reg      <= ST_FLUSH;
                flush_left_reg <= 4'(FLUSH_CYCLES - 1);
            end else if (in_flush && (flush_left_reg != 4'd0)) begin
                flush_left_reg <= flush_left_reg - 4'd1;
            end else begin
                state_reg <= hazard ? ST_STALL : ST_RUN;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule
